mac_array_sequencer: RTL and testbench

Job-level initiator that drives a `mac_array` instance. It accepts a start command, clears the selected accumulators and streams input/weight beats from a ready/valid source into the array. It then waits for the per-channel results and returns them, with overflow and timeout status, on a ready/valid result port. It sits between the DMA/AXI-side buffers and the MAC datapath and owns all sequencing of `enable`/`clear_acc`.

---
 rtl/mac_array_sequencer_pkg.sv | 27 ++
 rtl/seq_result_capture.sv | 81 ++++++++
 rtl/mac_array_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_mac_array_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_array_sequencer_pkg.sv
// Shared types and helpers for the MAC array job sequencer.
// Holds the FSM state encoding, per-lane slice offsets and status bit positions.
package mac_array_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_RESULT = 3'd4
    } seq_state_e;

    // LSB of channel ch inside a packed per-channel data/weight bus
    function automatic int data_lsb(input int ch, input int data_width);
        return ch * data_width;
    endfunction

    // LSB of channel ch inside a packed per-channel result bus
    function automatic int out_lsb(input int ch, input int output_width);
        return ch * output_width;
    endfunction

    // Status word layout: {done[NUM_CHANNELS-1:0], timeout}
    localparam int STATUS_TIMEOUT_BIT = 0;
    localparam int STATUS_DONE_LSB    = 1;

endpackage

// File: rtl/seq_result_capture.sv
// Per-channel done/capture register bank: grabs result, activation and overflow once per job.
// Capture lands one cycle after cap_en with mac_valid; done_next gives the same-cycle view.
module seq_result_capture
    import mac_array_sequencer_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int OUTPUT_WIDTH = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clr,
    input  logic                                 cap_en,
    input  logic [NUM_CHANNELS-1:0]              mask,
    input  logic [NUM_CHANNELS-1:0]              mac_valid,
    input  logic [NUM_CHANNELS-1:0]              mac_overflow,
    input  logic [OUTPUT_WIDTH*NUM_CHANNELS-1:0] mac_out,
    input  logic [OUTPUT_WIDTH*NUM_CHANNELS-1:0] mac_activated_out,
    output logic [NUM_CHANNELS-1:0]              done_next,
    output logic [NUM_CHANNELS-1:0]              done,
    output logic [NUM_CHANNELS-1:0]              overflow,
    output logic [OUTPUT_WIDTH*NUM_CHANNELS-1:0] result,
    output logic [OUTPUT_WIDTH*NUM_CHANNELS-1:0] activated
);

    logic [NUM_CHANNELS-1:0]              take;
    logic [NUM_CHANNELS-1:0]              done_q, done_d;
    logic [NUM_CHANNELS-1:0]              ovf_q, ovf_d;
    logic [OUTPUT_WIDTH*NUM_CHANNELS-1:0] result_q, result_d;
    logic [OUTPUT_WIDTH*NUM_CHANNELS-1:0] act_q, act_d;

    // A lane captures only once per job, and only if it belongs to the job
    for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_lane
        assign take[ch] = cap_en & mask[ch] & mac_valid[ch] & ~done_q[ch];
    end

    assign done_next = done_q | take;

    always_comb begin
        done_d   = done_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        act_d    = act_q;
        if (clr) begin
            done_d   = '0;
            ovf_d    = '0;
            result_d = '0;
            act_d    = '0;
        end else begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                if (take[ch]) begin
                    done_d[ch] = 1'b1;
                    ovf_d[ch]  = mac_overflow[ch];
                    result_d[out_lsb(ch, OUTPUT_WIDTH) +: OUTPUT_WIDTH] =
                        mac_out[out_lsb(ch, OUTPUT_WIDTH) +: OUTPUT_WIDTH];
                    act_d[out_lsb(ch, OUTPUT_WIDTH) +: OUTPUT_WIDTH] =
                        mac_activated_out[out_lsb(ch, OUTPUT_WIDTH) +: OUTPUT_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q   <= '0;
            ovf_q    <= '0;
            result_q <= '0;
            act_q    <= '0;
        end else begin
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            act_q    <= act_d;
        end
    end

    assign done      = done_q;
    assign overflow  = ovf_q;
    assign result    = result_q;
    assign activated = act_q;

endmodule

// File: rtl/mac_array_sequencer.sv
// Job sequencer for mac_array: clear, stream beats, drain results; start->m_valid is 2+len+MAC_LATENCY+1 min.
// s_ready only in STREAM (1 beat/cycle); m_valid is registered and holds until m_ready.
module mac_array_sequencer
    import mac_array_sequencer_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int OUTPUT_WIDTH = 16,
    parameter int LEN_WIDTH    = 8,
    parameter int MAC_LATENCY  = 1,
    parameter int TIMEOUT      = 15
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [LEN_WIDTH-1:0]                 job_len,
    input  logic [NUM_CHANNELS-1:0]              channel_mask,
    output logic                                 busy,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [DATA_WIDTH*NUM_CHANNELS-1:0]   s_data,
    input  logic [DATA_WIDTH*NUM_CHANNELS-1:0]   s_weight,
    output logic [NUM_CHANNELS-1:0]              mac_enable,
    output logic [NUM_CHANNELS-1:0]              mac_clear_acc,
    output logic [DATA_WIDTH*NUM_CHANNELS-1:0]   mac_input_data,
    output logic [DATA_WIDTH*NUM_CHANNELS-1:0]   mac_weight,
    input  logic [OUTPUT_WIDTH*NUM_CHANNELS-1:0] mac_out,
    input  logic [OUTPUT_WIDTH*NUM_CHANNELS-1:0] mac_activated_out,
    input  logic [NUM_CHANNELS-1:0]              mac_valid,
    input  logic [NUM_CHANNELS-1:0]              mac_overflow,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [OUTPUT_WIDTH*NUM_CHANNELS-1:0] m_result,
    output logic [OUTPUT_WIDTH*NUM_CHANNELS-1:0] m_activated,
    output logic [NUM_CHANNELS-1:0]              m_overflow,
    output logic [NUM_CHANNELS-1:0]              m_done,
    output logic                                 m_timeout
);

    localparam int LW = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY + 1) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [LW-1:0] LAT_INIT = LW'(MAC_LATENCY);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    seq_state_e                        state_q, state_d;
    logic [LEN_WIDTH-1:0]              beat_cnt_q, beat_cnt_d;
    logic [NUM_CHANNELS-1:0]           mask_q, mask_d;
    logic [LW-1:0]                     lat_cnt_q, lat_cnt_d;
    logic [TW-1:0]                     to_cnt_q, to_cnt_d;
    logic                              timeout_q, timeout_d;
    logic                              busy_q, busy_d;
    logic                              s_ready_q, s_ready_d;
    logic                              m_valid_q, m_valid_d;
    logic [NUM_CHANNELS-1:0]           mac_enable_q, mac_enable_d;
    logic [NUM_CHANNELS-1:0]           mac_clear_acc_q, mac_clear_acc_d;
    logic [DATA_WIDTH*NUM_CHANNELS-1:0] mac_input_data_q, mac_input_data_d;
    logic [DATA_WIDTH*NUM_CHANNELS-1:0] mac_weight_q, mac_weight_d;

    logic                    handshake;
    logic                    cap_clr;
    logic                    cap_en;
    logic [NUM_CHANNELS-1:0] done_next;
    logic [NUM_CHANNELS-1:0] done;
    logic [NUM_CHANNELS:0]   status;

    assign handshake = s_valid & s_ready_q;

    always_comb begin
        state_d          = state_q;
        beat_cnt_d       = beat_cnt_q;
        mask_d           = mask_q;
        lat_cnt_d        = lat_cnt_q;
        to_cnt_d         = to_cnt_q;
        timeout_d        = timeout_q;
        s_ready_d        = s_ready_q;
        m_valid_d        = m_valid_q;
        mac_enable_d     = '0;
        mac_clear_acc_d  = '0;
        mac_input_data_d = mac_input_data_q;
        mac_weight_d     = mac_weight_q;
        cap_clr          = 1'b0;
        cap_en           = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d         = ST_CLEAR;
                    beat_cnt_d      = job_len;
                    mask_d          = channel_mask;
                    mac_clear_acc_d = channel_mask;
                    timeout_d       = 1'b0;
                    cap_clr         = 1'b1;
                end
            end
            ST_CLEAR: begin
                lat_cnt_d = LAT_INIT;
                to_cnt_d  = '0;
                if (beat_cnt_q == '0) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d   = ST_STREAM;
                    s_ready_d = 1'b1;
                end
            end
            ST_STREAM: begin
                if (handshake) begin
                    mac_enable_d     = mask_q;
                    mac_input_data_d = s_data;
                    mac_weight_d     = s_weight;
                    beat_cnt_d       = beat_cnt_q - LEN_WIDTH'(1);
                    if (beat_cnt_q == LEN_WIDTH'(1)) begin
                        state_d   = ST_DRAIN;
                        s_ready_d = 1'b0;
                    end
                end
            end
            ST_DRAIN: begin
                // Results are only trusted once the array latency has elapsed
                if (lat_cnt_q != '0) begin
                    lat_cnt_d = lat_cnt_q - LW'(1);
                end else begin
                    cap_en = 1'b1;
                    if (done_next == mask_q) begin
                        state_d   = ST_RESULT;
                        m_valid_d = 1'b1;
                    end else if (to_cnt_q == TO_LAST) begin
                        state_d   = ST_RESULT;
                        m_valid_d = 1'b1;
                        timeout_d = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + TW'(1);
                    end
                end
            end
            ST_RESULT: begin
                if (m_ready) begin
                    state_d   = ST_IDLE;
                    m_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            beat_cnt_q       <= '0;
            mask_q           <= '0;
            lat_cnt_q        <= '0;
            to_cnt_q         <= '0;
            timeout_q        <= 1'b0;
            busy_q           <= 1'b0;
            s_ready_q        <= 1'b0;
            m_valid_q        <= 1'b0;
            mac_enable_q     <= '0;
            mac_clear_acc_q  <= '0;
            mac_input_data_q <= '0;
            mac_weight_q     <= '0;
        end else begin
            state_q          <= state_d;
            beat_cnt_q       <= beat_cnt_d;
            mask_q           <= mask_d;
            lat_cnt_q        <= lat_cnt_d;
            to_cnt_q         <= to_cnt_d;
            timeout_q        <= timeout_d;
            busy_q           <= busy_d;
            s_ready_q        <= s_ready_d;
            m_valid_q        <= m_valid_d;
            mac_enable_q     <= mac_enable_d;
            mac_clear_acc_q  <= mac_clear_acc_d;
            mac_input_data_q <= mac_input_data_d;
            mac_weight_q     <= mac_weight_d;
        end
    end

    seq_result_capture #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .OUTPUT_WIDTH (OUTPUT_WIDTH)
    ) u_capture (
        .clk               (clk),
        .rst               (rst),
        .clr               (cap_clr),
        .cap_en            (cap_en),
        .mask              (mask_q),
        .mac_valid         (mac_valid),
        .mac_overflow      (mac_overflow),
        .mac_out           (mac_out),
        .mac_activated_out (mac_activated_out),
        .done_next         (done_next),
        .done              (done),
        .overflow          (m_overflow),
        .result            (m_result),
        .activated         (m_activated)
    );

    assign status         = {done, timeout_q};
    assign m_timeout      = status[STATUS_TIMEOUT_BIT];
    assign m_done         = status[STATUS_DONE_LSB +: NUM_CHANNELS];
    assign busy           = busy_q;
    assign s_ready        = s_ready_q;
    assign m_valid        = m_valid_q;
    assign mac_enable     = mac_enable_q;
    assign mac_clear_acc  = mac_clear_acc_q;
    assign mac_input_data = mac_input_data_q;
    assign mac_weight     = mac_weight_q;

endmodule

// File: tb/tb_mac_array_sequencer.sv
// Directed bench for mac_array_sequencer with a small behavioural MAC array (latency 1).
module tb_mac_array_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  job_len = '0;
    logic [3:0]  channel_mask = '0;
    logic        busy;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = {4{8'h01}};
    logic [31:0] s_weight = {4{8'h02}};
    logic [3:0]  mac_enable;
    logic [3:0]  mac_clear_acc;
    logic [31:0] mac_input_data;
    logic [31:0] mac_weight;
    logic [63:0] mac_out;
    logic [63:0] mac_activated_out;
    logic [3:0]  mac_valid;
    logic [3:0]  mac_overflow;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [63:0] m_result;
    logic [63:0] m_activated;
    logic [3:0]  m_overflow;
    logic [3:0]  m_done;
    logic        m_timeout;

    logic [3:0]  valid_en = 4'hF;
    logic [3:0]  ovf_drive = 4'h0;
    logic [15:0] acc [4];
    logic [31:0] en_cnt = '0;
    logic [31:0] clr_cnt = '0;
    logic [211:0] all_outs;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mac_array_sequencer dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .job_len           (job_len),
        .channel_mask      (channel_mask),
        .busy              (busy),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .s_data            (s_data),
        .s_weight          (s_weight),
        .mac_enable        (mac_enable),
        .mac_clear_acc     (mac_clear_acc),
        .mac_input_data    (mac_input_data),
        .mac_weight        (mac_weight),
        .mac_out           (mac_out),
        .mac_activated_out (mac_activated_out),
        .mac_valid         (mac_valid),
        .mac_overflow      (mac_overflow),
        .m_valid           (m_valid),
        .m_ready           (m_ready),
        .m_result          (m_result),
        .m_activated       (m_activated),
        .m_overflow        (m_overflow),
        .m_done            (m_done),
        .m_timeout         (m_timeout)
    );

    // Behavioural array: result of an enable is visible the following cycle
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mac_clear_acc[i])
                acc[i] <= 16'd0;
            else if (mac_enable[i])
                acc[i] <= acc[i] + 16'(mac_input_data[8*i +: 8]) * 16'(mac_weight[8*i +: 8]);
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_arr
        assign mac_out[16*g +: 16]           = acc[g];
        assign mac_activated_out[16*g +: 16] = acc[g] + 16'd100;
    end
    assign mac_valid    = valid_en;
    assign mac_overflow = ovf_drive;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mac_enable[i] === 1'b1)    en_cnt[8*i +: 8]  <= en_cnt[8*i +: 8] + 8'd1;
            if (mac_clear_acc[i] === 1'b1) clr_cnt[8*i +: 8] <= clr_cnt[8*i +: 8] + 8'd1;
        end
    end

    assign all_outs = {busy, s_ready, mac_enable, mac_clear_acc, mac_input_data, mac_weight,
                       m_valid, m_result, m_activated, m_overflow, m_done, m_timeout};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one job and feeds beats; returns negedges from start to m_valid
    task automatic run_job(input logic [7:0] len, input logic [3:0] mask, input bit stall,
                           output int lat);
        int remaining;
        bit tog;
        remaining = len;
        tog = 1'b0;
        lat = 0;
        @(negedge clk);
        start = 1'b1;
        job_len = len;
        channel_mask = mask;
        while (1) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (m_valid) break;
            if (lat > 200) begin
                check("job_completion_bound", m_valid, 1'b1);
                break;
            end
            if (remaining > 0) begin
                if (stall) begin
                    tog = !tog;
                    s_valid = tog;
                end else begin
                    s_valid = 1'b1;
                end
            end else begin
                s_valid = 1'b0;
            end
            if (s_valid && s_ready) remaining--;
        end
        s_valid = 1'b0;
    endtask

    task automatic accept_result();
        @(negedge clk);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check("post_accept_m_valid", m_valid, 1'b0);
        check("post_accept_busy", busy, 1'b0);
    endtask

    initial begin
        int lat;
        int beats;
        int guard;
        logic [31:0] en_base;
        logic [31:0] clr_base;

        repeat (3) @(negedge clk);
        check("reset_outputs_zero", $countones(all_outs), 0);
        check("reset_busy", busy, 1'b0);
        rst = 1'b0;

        // Basic job
        en_base = en_cnt; clr_base = clr_cnt;
        run_job(8'd3, 4'hF, 1'b0, lat);
        check("basic_latency", lat, 7);
        check("basic_result", m_result, {4{16'd6}});
        check("basic_activated", m_activated, {4{16'd106}});
        check("basic_done", m_done, 4'hF);
        check("basic_timeout", m_timeout, 1'b0);
        check("basic_overflow", m_overflow, 4'h0);
        check("basic_enable_count", en_cnt - en_base, 32'h0303_0303);
        check("basic_clear_count", clr_cnt - clr_base, 32'h0101_0101);
        check("basic_data_hold", {mac_input_data, mac_weight}, {{4{8'h01}}, {4{8'h02}}});
        accept_result();

        // Partial mask with stalls
        en_base = en_cnt; clr_base = clr_cnt;
        run_job(8'd4, 4'b0101, 1'b1, lat);
        check("partial_latency", lat, 12);
        check("partial_enable_count", en_cnt - en_base, 32'h0004_0004);
        check("partial_clear_count", clr_cnt - clr_base, 32'h0001_0001);
        check("partial_result", m_result, 64'h0000_0008_0000_0008);
        check("partial_done", m_done, 4'b0101);
        accept_result();

        // Zero-length job
        en_base = en_cnt; clr_base = clr_cnt;
        run_job(8'd0, 4'hF, 1'b0, lat);
        check("zero_latency", lat, 4);
        check("zero_enable_count", en_cnt - en_base, 32'h0);
        check("zero_clear_count", clr_cnt - clr_base, 32'h0101_0101);
        check("zero_result", m_result, 64'h0);
        check("zero_activated", m_activated, {4{16'd100}});
        check("zero_done", m_done, 4'hF);
        accept_result();

        // Timeout: channel 2 never reports valid
        valid_en = 4'b1011;
        run_job(8'd2, 4'hF, 1'b0, lat);
        check("timeout_latency", lat, 20);
        check("timeout_flag", m_timeout, 1'b1);
        check("timeout_done", m_done, 4'b1011);
        check("timeout_result", m_result, 64'h0004_0000_0004_0004);
        accept_result();
        valid_en = 4'hF;

        // Overflow capture, back-pressure and ignored start
        ovf_drive = 4'b1010;
        run_job(8'd1, 4'b0111, 1'b0, lat);
        check("ovf_latency", lat, 5);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b1;
                job_len = 8'd3;
                channel_mask = 4'hF;
            end else begin
                start = 1'b0;
            end
            check("bp_m_valid_hold", m_valid, 1'b1);
            check("bp_overflow_hold", m_overflow, 4'b0010);
        end
        check("bp_result_hold", m_result, 64'h0000_0002_0002_0002);
        accept_result();
        @(negedge clk);
        check("ignored_start_busy", busy, 1'b0);
        check("ignored_start_clear", mac_clear_acc, 4'h0);
        ovf_drive = 4'h0;

        // Reset mid-stream after two beats
        @(negedge clk);
        start = 1'b1;
        job_len = 8'd5;
        channel_mask = 4'hF;
        beats = 0;
        guard = 0;
        while (beats < 2 && guard < 50) begin
            @(negedge clk);
            start = 1'b0;
            s_valid = 1'b1;
            if (s_ready) beats++;
            guard++;
        end
        check("midrst_beats_seen", beats, 2);
        @(negedge clk);
        s_valid = 1'b0;
        check("midrst_pre_enable", mac_enable, 4'hF);
        rst = 1'b1;
        #1;
        check("midrst_outputs_zero", $countones(all_outs), 0);
        check("midrst_busy", busy, 1'b0);
        en_base = en_cnt; clr_base = clr_cnt;
        repeat (3) @(negedge clk);
        check("midrst_no_pulses", {en_cnt - en_base, clr_cnt - clr_base}, 64'h0);
        rst = 1'b0;
        run_job(8'd3, 4'hF, 1'b0, lat);
        check("after_rst_latency", lat, 7);
        check("after_rst_result", m_result, {4{16'd6}});
        check("after_rst_done", m_done, 4'hF);
        accept_result();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
